// File: rtl/alu_issue_scheduler.sv
// Single-entry issue stage for the fixed-latency ALU: scoreboard hazard check, issue, writeback tags.
// Optional macro ALU_SCHED_BYPASS_EN lets the hazard check ignore registers retiring this cycle.
module alu_issue_scheduler #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_invalid,
    input  logic [3:0] in_a_sel,
    input  logic [3:0] in_b_sel,
    input  logic [3:0] in_c_sel,
    input  logic [3:0] in_d_sel,
    input  logic [3:0] in_src_mask,
    input  logic [3:0] in_y1_sel,
    input  logic [3:0] in_y2_sel,
    input  logic [1:0] in_write,
    input  logic       flush,
    output logic       issue_valid,
    output logic [3:0] issue_a_sel,
    output logic [3:0] issue_b_sel,
    output logic [3:0] issue_c_sel,
    output logic [3:0] issue_d_sel,
    output logic [3:0] issue_y1_sel,
    output logic [3:0] issue_y2_sel,
    output logic [1:0] issue_write,
    output logic [1:0] wb_valid,
    output logic [3:0] wb_y1_sel,
    output logic [3:0] wb_y2_sel,
    output logic [15:0] busy_regs,
    output logic       err_invalid,
    output logic       idle
);
    typedef enum logic {EMPTY, PENDING} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_a, r_b, r_c, r_d, r_mask, r_y1, r_y2;
    logic [1:0]  r_write;
    logic        r_invalid;
    logic [15:0] r_busy;
    logic [1:0]  r_wr_p [LATENCY];
    logic [3:0]  r_y1_p [LATENCY];
    logic [3:0]  r_y2_p [LATENCY];

    logic        w_ready, w_issue, w_drop, w_hazard, w_raw, w_waw, w_inflight;
    logic [1:0]  w_wr_eff;
    logic [15:0] w_set, w_ret, w_busy_chk, w_busy_nz;

    function automatic logic [15:0] reg_bit(input logic [3:0] sel, input logic en);
        return en ? (16'h1 << sel) : 16'h0;
    endfunction

    // Writes to the zero register are dropped before they reach the scoreboard or the pipeline
    assign w_wr_eff = {r_write[1] & (r_y2 != 4'd0), r_write[0] & (r_y1 != 4'd0)};
    assign w_set    = reg_bit(r_y1, w_wr_eff[0] & w_issue) | reg_bit(r_y2, w_wr_eff[1] & w_issue);
    assign w_ret    = reg_bit(r_y1_p[LATENCY-1], r_wr_p[LATENCY-1][0])
                    | reg_bit(r_y2_p[LATENCY-1], r_wr_p[LATENCY-1][1]);

    // r_busy still covers the retiring tag; the visible scoreboard already shows it free
    assign busy_regs = r_busy & ~w_ret;
`ifdef ALU_SCHED_BYPASS_EN
    assign w_busy_chk = busy_regs;
`else
    assign w_busy_chk = r_busy;
`endif
    assign w_busy_nz = w_busy_chk & 16'hFFFE;
    assign w_raw = (r_mask[3] & w_busy_nz[r_a]) | (r_mask[2] & w_busy_nz[r_b])
                 | (r_mask[1] & w_busy_nz[r_c]) | (r_mask[0] & w_busy_nz[r_d]);
    assign w_waw = (w_wr_eff[0] & w_busy_nz[r_y1]) | (w_wr_eff[1] & w_busy_nz[r_y2]);
    assign w_hazard = w_raw | w_waw;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_issue     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            EMPTY:   w_ready = !flush;
            PENDING: begin
                if (!flush) begin
                    if (r_invalid)      w_drop  = 1'b1;
                    else if (!w_hazard) w_issue = 1'b1;
                    w_ready = w_issue | w_drop;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush)                     w_state_nxt = EMPTY;
        else if (in_valid && w_ready)  w_state_nxt = PENDING;
        else if (w_issue || w_drop)    w_state_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
            r_mask <= '0; r_y1 <= '0; r_y2 <= '0; r_write <= '0; r_invalid <= 1'b0;
        end else if (in_valid && w_ready) begin
            r_a <= in_a_sel; r_b <= in_b_sel; r_c <= in_c_sel; r_d <= in_d_sel;
            r_mask <= in_src_mask; r_y1 <= in_y1_sel; r_y2 <= in_y2_sel;
            r_write <= in_write; r_invalid <= in_invalid;
        end
    end

    // Set after clear so a reissue to a retiring register keeps it busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= (r_busy & ~w_ret) | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_wr_p[i] <= '0;
                r_y1_p[i] <= '0;
                r_y2_p[i] <= '0;
            end
        end else begin
            r_wr_p[0] <= w_issue ? w_wr_eff : 2'b00;
            r_y1_p[0] <= r_y1;
            r_y2_p[0] <= r_y2;
            for (int i = 1; i < LATENCY; i++) begin
                r_wr_p[i] <= r_wr_p[i-1];
                r_y1_p[i] <= r_y1_p[i-1];
                r_y2_p[i] <= r_y2_p[i-1];
            end
        end
    end

    always_comb begin
        w_inflight = 1'b0;
        for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight | (|r_wr_p[i]);
    end

    assign in_ready     = w_ready;
    assign issue_valid  = w_issue;
    assign err_invalid  = w_drop;
    assign issue_a_sel  = r_a;
    assign issue_b_sel  = r_b;
    assign issue_c_sel  = r_c;
    assign issue_d_sel  = r_d;
    assign issue_y1_sel = r_y1;
    assign issue_y2_sel = r_y2;
    assign issue_write  = w_wr_eff;
    assign wb_valid     = r_wr_p[LATENCY-1];
    assign wb_y1_sel    = r_y1_p[LATENCY-1];
    assign wb_y2_sel    = r_y2_p[LATENCY-1];
    assign idle         = (r_state == EMPTY) && !w_inflight;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler at LATENCY = 2 with hand-computed expectations.
module tb_alu_issue_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_invalid = 1'b0, flush = 1'b0;
    logic [3:0] in_a_sel = '0, in_b_sel = '0, in_c_sel = '0, in_d_sel = '0;
    logic [3:0] in_src_mask = '0, in_y1_sel = '0, in_y2_sel = '0;
    logic [1:0] in_write = '0;
    logic       in_ready, issue_valid, err_invalid, idle;
    logic [3:0] issue_a_sel, issue_b_sel, issue_c_sel, issue_d_sel, issue_y1_sel, issue_y2_sel;
    logic [1:0] issue_write, wb_valid;
    logic [3:0] wb_y1_sel, wb_y2_sel;
    logic [15:0] busy_regs;

    int n_chk = 0;
    int n_fail = 0;
    int k_issue;

    alu_issue_scheduler #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_invalid(in_invalid), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_c_sel(in_c_sel), .in_d_sel(in_d_sel), .in_src_mask(in_src_mask),
        .in_y1_sel(in_y1_sel), .in_y2_sel(in_y2_sel), .in_write(in_write),
        .flush(flush), .issue_valid(issue_valid), .issue_a_sel(issue_a_sel),
        .issue_b_sel(issue_b_sel), .issue_c_sel(issue_c_sel), .issue_d_sel(issue_d_sel),
        .issue_y1_sel(issue_y1_sel), .issue_y2_sel(issue_y2_sel), .issue_write(issue_write),
        .wb_valid(wb_valid), .wb_y1_sel(wb_y1_sel), .wb_y2_sel(wb_y2_sel),
        .busy_regs(busy_regs), .err_invalid(err_invalid), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] mask,
                         input logic [3:0] y1, input logic [3:0] y2, input logic [1:0] wr,
                         input logic inv);
        in_valid = 1'b1; in_invalid = inv;
        in_a_sel = a; in_b_sel = b; in_c_sel = 4'd0; in_d_sel = 4'd0;
        in_src_mask = mask; in_y1_sel = y1; in_y2_sel = y2; in_write = wr;
    endtask

    task automatic nodrive();
        in_valid = 1'b0; in_invalid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_busy", 32'(busy_regs), 32'd0);
        chk("rst_err", 32'(err_invalid), 32'd0);
        rst_n = 1'b1;

        // Single instruction y1 = 3
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd3, 4'd0, 2'b01, 1'b0);
        #1 chk("t1_ready", 32'(in_ready), 32'd1);
        tick(); nodrive();
        #1 chk("t1_issue", 32'(issue_valid), 32'd1);
        chk("t1_issue_y1", 32'(issue_y1_sel), 32'd3);
        chk("t1_issue_wr", 32'(issue_write), 32'd1);
        chk("t1_busy_pre", 32'(busy_regs), 32'd0);
        tick();
        #1 chk("t1_busy", 32'(busy_regs), 32'h0008);
        chk("t1_issue_off", 32'(issue_valid), 32'd0);
        chk("t1_wb_early", 32'(wb_valid), 32'd0);
        tick();
        #1 chk("t1_wb", 32'(wb_valid), 32'd1);
        chk("t1_wb_y1", 32'(wb_y1_sel), 32'd3);
        chk("t1_busy_clr", 32'(busy_regs), 32'd0);
        chk("t1_idle_busy", 32'(idle), 32'd0);
        tick();
        #1 chk("t1_wb_off", 32'(wb_valid), 32'd0);
        chk("t1_idle", 32'(idle), 32'd1);

        // RAW: producer r5, consumer reads r5 via a
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd5, 4'd0, 2'b01, 1'b0);
        tick();
        drive(4'd5, 4'd0, 4'b1000, 4'd0, 4'd0, 2'b00, 1'b0);
        #1 chk("raw_prod_issue", 32'(issue_valid), 32'd1);
        k_issue = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(); nodrive();
            #1;
            if (k == 1) chk("raw_stall_ready", 32'(in_ready), 32'd0);
            if (issue_valid && k_issue == 0) begin
                k_issue = k;
                chk("raw_cons_a", 32'(issue_a_sel), 32'd5);
            end
        end
`ifdef ALU_SCHED_BYPASS_EN
        chk("raw_spacing", 32'(k_issue), 32'd2);
`else
        chk("raw_spacing", 32'(k_issue), 32'd3);
`endif
        chk("raw_idle", 32'(idle), 32'd1);

        // Zero register: no hazard, no write
        tick();
        drive(4'd0, 4'd0, 4'b1000, 4'd0, 4'd0, 2'b01, 1'b0);
        tick(); nodrive();
        #1 chk("zero_issue", 32'(issue_valid), 32'd1);
        chk("zero_issue_wr", 32'(issue_write), 32'd0);
        tick();
        #1 chk("zero_busy", 32'(busy_regs), 32'd0);
        tick();
        #1 chk("zero_wb", 32'(wb_valid), 32'd0);

        // Invalid instruction dropped
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd4, 4'd0, 2'b01, 1'b1);
        tick(); nodrive();
        #1 chk("inv_err", 32'(err_invalid), 32'd1);
        chk("inv_issue", 32'(issue_valid), 32'd0);
        chk("inv_ready", 32'(in_ready), 32'd1);
        tick();
        #1 chk("inv_err_off", 32'(err_invalid), 32'd0);
        chk("inv_busy", 32'(busy_regs), 32'd0);
        chk("inv_idle", 32'(idle), 32'd1);

        // Flush a consumer stalled on r7
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd7, 4'd0, 2'b01, 1'b0);
        tick();
        drive(4'd0, 4'd7, 4'b0100, 4'd0, 4'd0, 2'b00, 1'b0);
        #1 chk("fl_prod_issue", 32'(issue_valid), 32'd1);
        tick(); nodrive(); flush = 1'b1;
        #1 chk("fl_ready", 32'(in_ready), 32'd0);
        chk("fl_issue", 32'(issue_valid), 32'd0);
        chk("fl_busy", 32'(busy_regs), 32'h0080);
        tick(); flush = 1'b0;
        #1 chk("fl_wb", 32'(wb_valid), 32'd1);
        chk("fl_wb_y1", 32'(wb_y1_sel), 32'd7);
        chk("fl_issue2", 32'(issue_valid), 32'd0);
        tick();
        #1 chk("fl_issue3", 32'(issue_valid), 32'd0);
        chk("fl_idle", 32'(idle), 32'd1);

        // Y1 == Y2 both enabled
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd6, 4'd6, 2'b11, 1'b0);
        tick(); nodrive();
        #1 chk("dup_issue_wr", 32'(issue_write), 32'd3);
        tick();
        #1 chk("dup_busy", 32'(busy_regs), 32'h0040);
        tick();
        #1 chk("dup_wb", 32'(wb_valid), 32'd3);
        chk("dup_wb_y2", 32'(wb_y2_sel), 32'd6);
        chk("dup_busy_clr", 32'(busy_regs), 32'd0);

        // Four independent back-to-back instructions, y1 = 8..11
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd8, 4'd0, 2'b01, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j <= 3) drive(4'd0, 4'd0, 4'b0000, 4'(8 + j), 4'd0, 2'b01, 1'b0);
            else nodrive();
            #1;
            if (j <= 4) begin
                chk("b2b_issue", 32'(issue_valid), 32'd1);
                chk("b2b_issue_y1", 32'(issue_y1_sel), 32'(7 + j));
            end else begin
                chk("b2b_issue_off", 32'(issue_valid), 32'd0);
            end
            if (j <= 3) chk("b2b_ready", 32'(in_ready), 32'd1);
            if (j >= 3) begin
                chk("b2b_wb", 32'(wb_valid), 32'd1);
                chk("b2b_wb_y1", 32'(wb_y1_sel), 32'(5 + j));
            end else begin
                chk("b2b_wb_off", 32'(wb_valid), 32'd0);
            end
        end

        // Reset mid-operation loses the in-flight writeback
        tick();
        drive(4'd0, 4'd0, 4'b0000, 4'd12, 4'd0, 2'b01, 1'b0);
        tick(); nodrive();
        tick();
        #1 chk("mr_busy_pre", 32'(busy_regs), 32'h1000);
        rst_n = 1'b0;
        #1 chk("mr_busy", 32'(busy_regs), 32'd0);
        chk("mr_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;
        tick();
        #1 chk("mr_wb", 32'(wb_valid), 32'd0);
        tick();
        #1 chk("mr_wb2", 32'(wb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
